color_classify: RTL and testbench

Parametrised RGB dominance classifier with sample-count debounce. It sits between `i2c_ctrl` and the board outputs, replacing the per-cycle compare on `data_r/g/b`. It classifies only on an explicit sample strobe, applies a configurable dominance margin and a darkness floor, and changes the reported colour only after `CONFIRM_N` consecutive agreeing samples.

---
 rtl/color_pkg.sv | 33 +++
 rtl/color_dom_cmp.sv | 72 +++++++
 rtl/color_classify.sv | 134 +++++++++++++
 tb/tb_color_classify.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/color_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | color_pkg : class/state encodings shared by the colour classifier     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package color_pkg;

  localparam logic [1:0] CLS_NONE = 2'd0;
  localparam logic [1:0] CLS_RED  = 2'd1;
  localparam logic [1:0] CLS_GRN  = 2'd2;
  localparam logic [1:0] CLS_BLU  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Returns {blue, green, red}; NONE decodes to all zero.
  function automatic logic [2:0] cls_onehot(input logic [1:0] cls);
    logic [2:0] oh;
    oh = 3'b000;
    case (cls)
      CLS_RED: oh = 3'b001;
      CLS_GRN: oh = 3'b010;
      CLS_BLU: oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/color_dom_cmp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | color_dom_cmp : registered RGB dominance candidate with darkness floor|
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module color_dom_cmp
  import color_pkg::*;
#(
  parameter int          DATA_W      = 24,
  parameter int          RATIO_SHIFT = 0,
  parameter int unsigned MIN_SUM     = 256
) (
  input  logic              i2c_clk,
  input  logic              sys_rst_n,
  input  logic              clr,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] data_r,
  input  logic [DATA_W-1:0] data_g,
  input  logic [DATA_W-1:0] data_b,
  output logic              cand_vld,
  output logic [1:0]        cand
);

  localparam int SUM_W  = DATA_W + 2;
  localparam int PAIR_W = DATA_W + 1;
  localparam int CMP_W  = DATA_W + 1 + RATIO_SHIFT;
  localparam logic [SUM_W-1:0] MIN_SUM_V = SUM_W'(MIN_SUM);

  logic [SUM_W-1:0]  sum;
  logic [PAIR_W-1:0] pair_gb, pair_rb, pair_rg;
  logic [CMP_W-1:0]  thr_r, thr_g, thr_b;
  logic [CMP_W-1:0]  ext_r, ext_g, ext_b;
  logic [1:0]        cand_d;

  // All arithmetic is widened so that no carry or shifted bit is lost.
  always_comb begin
    sum     = SUM_W'(data_r) + SUM_W'(data_g) + SUM_W'(data_b);
    pair_gb = PAIR_W'(data_g) + PAIR_W'(data_b);
    pair_rb = PAIR_W'(data_r) + PAIR_W'(data_b);
    pair_rg = PAIR_W'(data_r) + PAIR_W'(data_g);
    thr_r   = CMP_W'(pair_gb) << RATIO_SHIFT;
    thr_g   = CMP_W'(pair_rb) << RATIO_SHIFT;
    thr_b   = CMP_W'(pair_rg) << RATIO_SHIFT;
    ext_r   = CMP_W'(data_r);
    ext_g   = CMP_W'(data_g);
    ext_b   = CMP_W'(data_b);
  end

  always_comb begin
    cand_d = CLS_NONE;
    if (sum < MIN_SUM_V)   cand_d = CLS_NONE;
    else if (ext_r > thr_r) cand_d = CLS_RED;
    else if (ext_g > thr_g) cand_d = CLS_GRN;
    else if (ext_b > thr_b) cand_d = CLS_BLU;
    else                    cand_d = CLS_NONE;
  end

  always_ff @(posedge i2c_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cand_vld <= 1'b0;
      cand     <= CLS_NONE;
    end else if (clr) begin
      cand_vld <= 1'b0;
      cand     <= CLS_NONE;
    end else begin
      cand_vld <= sample_valid;
      if (sample_valid) cand <= cand_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/color_classify.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | color_classify : strobed RGB classifier with N-sample debounce;       |
// | COLOR_CLS_STAT_EN adds a saturating change_cnt output.  Rev 1.0       |
// +----------------------------------------------------------------------+
module color_classify
  import color_pkg::*;
#(
  parameter int          DATA_W      = 24,
  parameter int          CONFIRM_N   = 4,
  parameter int          RATIO_SHIFT = 0,
  parameter int unsigned MIN_SUM     = 256
) (
  input  logic              i2c_clk,
  input  logic              sys_rst_n,
  input  logic              sample_valid,
  input  logic              clr,
  input  logic [DATA_W-1:0] data_r,
  input  logic [DATA_W-1:0] data_g,
  input  logic [DATA_W-1:0] data_b,
  output logic              r_valid,
  output logic              g_valid,
  output logic              b_valid,
  output logic [1:0]        class_code,
  output logic              class_change
`ifdef COLOR_CLS_STAT_EN
  ,
  output logic [15:0]       change_cnt
`endif
);

  localparam int CNT_W = $clog2(CONFIRM_N + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CONFIRM_N);

  logic             cand_vld;
  logic [1:0]       cand;

  state_t           state, state_nxt;
  logic [1:0]       pending, pending_nxt;
  logic [1:0]       committed;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             sat;
  logic             commit;
  logic [2:0]       onehot_nxt;

  color_dom_cmp #(
    .DATA_W      (DATA_W),
    .RATIO_SHIFT (RATIO_SHIFT),
    .MIN_SUM     (MIN_SUM)
  ) u_dom_cmp (
    .i2c_clk      (i2c_clk),
    .sys_rst_n    (sys_rst_n),
    .clr          (clr),
    .sample_valid (sample_valid),
    .data_r       (data_r),
    .data_g       (data_g),
    .data_b       (data_b),
    .cand_vld     (cand_vld),
    .cand         (cand)
  );

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    cnt_nxt     = cnt;
    sat         = 1'b0;
    commit      = 1'b0;
    if (cand_vld) begin
      if (cand == pending) begin
        cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
      end else begin
        pending_nxt = cand;
        cnt_nxt     = CNT_W'(1);
      end
      sat    = (cnt_nxt == CNT_MAX);
      commit = sat && (pending_nxt != committed);
      // A saturated count always leaves pending == committed, hence LOCKED.
      case (state)
        ST_IDLE:   state_nxt = sat ? ST_LOCKED : ST_TRACK;
        ST_TRACK:  if (sat) state_nxt = ST_LOCKED;
        ST_LOCKED: if (!sat) state_nxt = ST_TRACK;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  assign onehot_nxt = cls_onehot(commit ? pending_nxt : committed);
  assign class_code = committed;

  always_ff @(posedge i2c_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= ST_IDLE;
      pending      <= CLS_NONE;
      cnt          <= '0;
      committed    <= CLS_NONE;
      class_change <= 1'b0;
      r_valid      <= 1'b0;
      g_valid      <= 1'b0;
      b_valid      <= 1'b0;
    end else if (clr) begin
      state        <= ST_IDLE;
      pending      <= CLS_NONE;
      cnt          <= '0;
      committed    <= CLS_NONE;
      class_change <= 1'b0;
      r_valid      <= 1'b0;
      g_valid      <= 1'b0;
      b_valid      <= 1'b0;
    end else begin
      state        <= state_nxt;
      pending      <= pending_nxt;
      cnt          <= cnt_nxt;
      class_change <= commit;
      if (commit) committed <= pending_nxt;
      r_valid      <= onehot_nxt[0];
      g_valid      <= onehot_nxt[1];
      b_valid      <= onehot_nxt[2];
    end
  end

`ifdef COLOR_CLS_STAT_EN
  always_ff @(posedge i2c_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      change_cnt <= 16'h0000;
    end else if (clr) begin
      change_cnt <= 16'h0000;
    end else if (commit && (change_cnt != 16'hFFFF)) begin
      change_cnt <= change_cnt + 16'h0001;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_color_classify.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_color_classify : table + scoreboard bench for color_classify       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_color_classify;

  logic        i2c_clk = 1'b0;
  logic        sys_rst_n;
  logic        sample_valid;
  logic        clr;
  logic [23:0] data_r, data_g, data_b;
  logic        sv_push;

  logic        r0, g0, b0, chg0, r1, g1, b1, chg1;
  logic [1:0]  code0, code1;
`ifdef COLOR_CLS_STAT_EN
  logic [15:0] cnt0, cnt1;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 i2c_clk = ~i2c_clk;

  color_classify #(.DATA_W(24), .CONFIRM_N(4), .RATIO_SHIFT(0), .MIN_SUM(256)) u_dut0 (
    .i2c_clk(i2c_clk), .sys_rst_n(sys_rst_n), .sample_valid(sample_valid), .clr(clr),
    .data_r(data_r), .data_g(data_g), .data_b(data_b),
    .r_valid(r0), .g_valid(g0), .b_valid(b0), .class_code(code0), .class_change(chg0)
`ifdef COLOR_CLS_STAT_EN
    , .change_cnt(cnt0)
`endif
  );

  color_classify #(.DATA_W(24), .CONFIRM_N(4), .RATIO_SHIFT(1), .MIN_SUM(256)) u_dut1 (
    .i2c_clk(i2c_clk), .sys_rst_n(sys_rst_n), .sample_valid(sample_valid), .clr(clr),
    .data_r(data_r), .data_g(data_g), .data_b(data_b),
    .r_valid(r1), .g_valid(g1), .b_valid(b1), .class_code(code1), .class_change(chg1)
`ifdef COLOR_CLS_STAT_EN
    , .change_cnt(cnt1)
`endif
  );

  typedef struct {
    logic        clr_first;
    logic        inst;
    logic [23:0] r, g, b;
    logic [1:0]  code;
    logic        chg;
  } vec_t;

  typedef struct {
    logic       inst;
    logic [1:0] code;
    logic       chg;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  logic [1:0] pipe = 2'b00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i2c_clk);
      #1;
    end
  endtask

  task automatic strobe(input logic [23:0] r, input logic [23:0] g, input logic [23:0] b,
                        input logic push, input logic inst, input logic [1:0] code,
                        input logic chg);
    data_r       = r;
    data_g       = g;
    data_b       = b;
    sample_valid = 1'b1;
    sv_push      = push;
    if (push && !clr) exp_q.push_back('{inst, code, chg});
    @(posedge i2c_clk);
    #1;
    sample_valid = 1'b0;
    sv_push      = 1'b0;
  endtask

  task automatic add(input logic c, input logic inst, input int r, input int g, input int b,
                     input logic [1:0] code, input logic chg);
    vecs.push_back('{c, inst, 24'(r), 24'(g), 24'(b), code, chg});
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
  endtask

  // Each pushed strobe surfaces on the outputs two cycles later.
  always @(negedge i2c_clk) begin
    exp_t e;
    logic [1:0] ac;
    logic [2:0] av;
    logic       ach;
    if (!sys_rst_n) begin
      pipe = 2'b00;
      exp_q.delete();
    end else begin
      if (pipe[1]) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_underflow: got empty queue, required an expectation");
        end else begin
          e   = exp_q.pop_front();
          ac  = e.inst ? code1 : code0;
          av  = e.inst ? {b1, g1, r1} : {b0, g0, r0};
          ach = e.inst ? chg1 : chg0;
          check("sb_class_code", 32'(ac), 32'(e.code));
          check("sb_valid_onehot", 32'(av),
                32'({e.code == 2'd3, e.code == 2'd2, e.code == 2'd1}));
          check("sb_class_change", 32'(ach), 32'(e.chg));
        end
      end
      pipe = {pipe[0], sample_valid && sv_push && !clr};
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: got no finish, required finish within budget");
    $fatal(1, "timeout");
  end

  initial begin
    sys_rst_n    = 1'b0;
    clr          = 1'b0;
    sample_valid = 1'b0;
    sv_push      = 1'b0;
    data_r       = '0;
    data_g       = '0;
    data_b       = '0;

    // Red lock-in, then debounce break to green
    add(1, 0, 1000, 100, 100, 0, 0);
    add(0, 0, 1000, 100, 100, 0, 0);
    add(0, 0, 1000, 100, 100, 0, 0);
    add(0, 0, 1000, 100, 100, 1, 1);
    add(0, 0, 50, 900, 50, 1, 0);
    add(0, 0, 50, 900, 50, 1, 0);
    add(0, 0, 50, 900, 50, 1, 0);
    add(0, 0, 50, 50, 900, 1, 0);
    add(0, 0, 50, 900, 50, 1, 0);
    add(0, 0, 50, 900, 50, 1, 0);
    add(0, 0, 50, 900, 50, 1, 0);
    add(0, 0, 50, 900, 50, 2, 1);
    add(0, 0, 50, 900, 50, 2, 0);
    // Dark floor
    add(1, 0, 200, 20, 20, 0, 0);
    add(0, 0, 200, 20, 20, 0, 0);
    add(0, 0, 200, 20, 20, 0, 0);
    add(0, 0, 200, 20, 20, 0, 0);
    add(0, 0, 220, 20, 20, 0, 0);
    add(0, 0, 220, 20, 20, 0, 0);
    add(0, 0, 220, 20, 20, 0, 0);
    add(0, 0, 220, 20, 20, 1, 1);
    // Ratio margin on the RATIO_SHIFT=1 instance
    add(1, 1, 500, 150, 100, 0, 0);
    add(0, 1, 500, 150, 100, 0, 0);
    add(0, 1, 500, 150, 100, 0, 0);
    add(0, 1, 500, 150, 100, 0, 0);
    add(0, 1, 501, 150, 100, 0, 0);
    add(0, 1, 501, 150, 100, 0, 0);
    add(0, 1, 501, 150, 100, 0, 0);
    add(0, 1, 501, 150, 100, 1, 1);
    // NONE -> RED -> GREEN -> NONE
    add(1, 0, 1000, 100, 100, 0, 0);
    add(0, 0, 1000, 100, 100, 0, 0);
    add(0, 0, 1000, 100, 100, 0, 0);
    add(0, 0, 1000, 100, 100, 1, 1);
    add(0, 0, 50, 900, 50, 1, 0);
    add(0, 0, 50, 900, 50, 1, 0);
    add(0, 0, 50, 900, 50, 1, 0);
    add(0, 0, 50, 900, 50, 2, 1);
    add(0, 0, 300, 300, 300, 2, 0);
    add(0, 0, 300, 300, 300, 2, 0);
    add(0, 0, 300, 300, 300, 2, 0);
    add(0, 0, 300, 300, 300, 0, 1);
    add(0, 0, 300, 300, 300, 0, 0);

    idle(3);
    check("rst_class_code", 32'(code0), 32'd0);
    check("rst_valids", 32'({b0, g0, r0}), 32'd0);
    check("rst_class_change", 32'(chg0), 32'd0);
`ifdef COLOR_CLS_STAT_EN
    check("rst_change_cnt", 32'(cnt0), 32'd0);
`endif
    sys_rst_n = 1'b1;
    idle(2);

    foreach (vecs[i]) begin
      if (vecs[i].clr_first) begin
        idle(3);
        pulse_clr();
      end
      strobe(vecs[i].r, vecs[i].g, vecs[i].b, 1'b1, vecs[i].inst, vecs[i].code, vecs[i].chg);
    end
    idle(3);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

`ifdef COLOR_CLS_STAT_EN
    check("stat_change_cnt", 32'(cnt0), 32'd3);
    pulse_clr();
    check("stat_cnt_after_clr", 32'(cnt0), 32'd0);
`endif

    // Lock BLUE, then clr coincident with a red sample
    pulse_clr();
    repeat (4) strobe(24'd50, 24'd50, 24'd900, 1'b0, 1'b0, 2'd0, 1'b0);
    idle(1);
    check("blue_locked_code", 32'(code0), 32'd3);
    check("blue_locked_bvalid", 32'(b0), 32'd1);
    data_r       = 24'd1000;
    data_g       = 24'd100;
    data_b       = 24'd100;
    clr          = 1'b1;
    sample_valid = 1'b1;
    idle(1);
    clr          = 1'b0;
    sample_valid = 1'b0;
    check("clr_code", 32'(code0), 32'd0);
    check("clr_valids", 32'({b0, g0, r0}), 32'd0);
    check("clr_no_pulse", 32'(chg0), 32'd0);
    idle(1);
    check("clr_no_pulse_late", 32'(chg0), 32'd0);
    repeat (3) strobe(24'd1000, 24'd100, 24'd100, 1'b0, 1'b0, 2'd0, 1'b0);
    idle(2);
    check("clr_sample_discarded", 32'(code0), 32'd0);
    strobe(24'd1000, 24'd100, 24'd100, 1'b0, 1'b0, 2'd0, 1'b0);
    idle(1);
    check("post_clr_red_commit", 32'(code0), 32'd1);

    // Lock GREEN, then asynchronous reset in the middle of a red count
    repeat (4) strobe(24'd50, 24'd900, 24'd50, 1'b0, 1'b0, 2'd0, 1'b0);
    idle(1);
    check("green_locked_code", 32'(code0), 32'd2);
    repeat (2) strobe(24'd1000, 24'd100, 24'd100, 1'b0, 1'b0, 2'd0, 1'b0);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("async_rst_code", 32'(code0), 32'd0);
    check("async_rst_gvalid", 32'(g0), 32'd0);
    idle(1);
    sys_rst_n = 1'b1;
    repeat (2) strobe(24'd1000, 24'd100, 24'd100, 1'b0, 1'b0, 2'd0, 1'b0);
    idle(2);
    check("rst_count_lost", 32'(code0), 32'd0);
    repeat (2) strobe(24'd1000, 24'd100, 24'd100, 1'b0, 1'b0, 2'd0, 1'b0);
    idle(1);
    check("post_rst_red_commit", 32'(code0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
